// File: rtl/claw_motion_sequencer.sv
// Two-axis claw stepper sequencer: accepts relative moves and homing commands, drives enable/direction per axis.
// Latency: command accepted on a clk edge enters MOVE/HOME the next cycle; completion signalled by a one-cycle done pulse.
// Backpressure: cmd_ready is high only in IDLE; commands presented while busy are not queued.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   step_tick           - one-cycle pulse per motor step period
//   cmd_valid/cmd_ready - command handshake; cmd_axis (0=X,1=Y), cmd_home, cmd_dir (1=away from home), cmd_steps
//   limit_x, limit_y    - home limit switches (active-high, synchronised)
//   abort               - immediate stop, also the only way out of FAULT
//   en_*/dir_*          - motor driver enable/direction
//   pos_x, pos_y        - absolute positions in steps
//   busy, done, sat, fault - status
module claw_motion_sequencer #(
    parameter int POS_W    = 12,
    parameter int X_MAX    = 2000,
    parameter int Y_MAX    = 1500,
    parameter int HOME_MAX = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_axis,
    input  logic             cmd_home,
    input  logic             cmd_dir,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic             limit_x,
    input  logic             limit_y,
    input  logic             abort,
    output logic             en_x,
    output logic             dir_x,
    output logic             en_y,
    output logic             dir_y,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic             fault
);

    localparam int HC_W = $clog2(HOME_MAX + 1);

    localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_P    = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] ONE_P      = POS_W'(1);
    localparam logic [HC_W-1:0]  HOME_MAX_P = HC_W'(HOME_MAX);
    localparam logic [HC_W-1:0]  HC_ONE_P   = HC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_HOME  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // State and latched command
    state_t           r_state;
    logic             r_axis;
    logic             r_dir;
    logic [POS_W-1:0] r_rem;
    logic [HC_W-1:0]  r_hcnt;
    logic [POS_W-1:0] r_pos_x;
    logic [POS_W-1:0] r_pos_y;
    logic             r_sat;
    // Last driven direction per axis, so dir holds outside MOVE/HOME
    logic             r_dir_x;
    logic             r_dir_y;

    // Next-state and datapath controls
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_pos_inc;
    logic             w_pos_dec;
    logic             w_pos_clr;
    logic             w_rem_dec;
    logic             w_hcnt_inc;
    logic             w_set_sat;

    // Selected-axis views
    logic [POS_W-1:0] w_pos_sel;
    logic [POS_W-1:0] w_max_sel;
    logic             w_lim_sel;
    logic [HC_W-1:0]  w_hcnt_plus;
    logic             w_active;
    logic             w_dir_x;
    logic             w_dir_y;

    assign w_pos_sel   = r_axis ? r_pos_y : r_pos_x;
    assign w_max_sel   = r_axis ? Y_MAX_P : X_MAX_P;
    assign w_lim_sel   = r_axis ? limit_y : limit_x;
    assign w_hcnt_plus = r_hcnt + HC_ONE_P;

    // Next-state / control decode. Priority inside MOVE and HOME is
    // abort > limit switch > end-of-count > step_tick, so a limit or
    // soft-limit condition always suppresses the position update.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pos_inc   = 1'b0;
        w_pos_dec   = 1'b0;
        w_pos_clr   = 1'b0;
        w_rem_dec   = 1'b0;
        w_hcnt_inc  = 1'b0;
        w_set_sat   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_home ? S_HOME : S_MOVE;
                end
            end

            S_MOVE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_dir && w_lim_sel) begin
                    // Hit the home switch while moving toward it: position is known to be 0.
                    w_pos_clr   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_rem == '0) begin
                    // Zero-length command spends exactly one cycle here.
                    w_state_nxt = S_DONE;
                end else if (step_tick) begin
                    if (r_dir && (w_pos_sel >= w_max_sel)) begin
                        w_set_sat   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (!r_dir && (w_pos_sel == '0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pos_inc = r_dir;
                        w_pos_dec = !r_dir;
                        w_rem_dec = 1'b1;
                        if (r_rem == ONE_P) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end

            S_HOME: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_lim_sel) begin
                    w_pos_clr   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (step_tick) begin
                    w_hcnt_inc = 1'b1;
                    if (w_hcnt_plus >= HOME_MAX_P) begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            S_FAULT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Direction: latched dir while moving, 0 while homing, otherwise hold.
    always_comb begin
        w_dir_x = r_dir_x;
        w_dir_y = r_dir_y;
        if (r_state == S_MOVE) begin
            if (r_axis) w_dir_y = r_dir;
            else        w_dir_x = r_dir;
        end else if (r_state == S_HOME) begin
            if (r_axis) w_dir_y = 1'b0;
            else        w_dir_x = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_axis  <= 1'b0;
            r_dir   <= 1'b0;
            r_rem   <= '0;
            r_hcnt  <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_sat   <= 1'b0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir_x <= w_dir_x;
            r_dir_y <= w_dir_y;

            if (w_accept) begin
                r_axis <= cmd_axis;
                r_dir  <= cmd_dir;
                r_rem  <= cmd_steps;
                r_hcnt <= '0;
                r_sat  <= 1'b0;
            end

            if (w_set_sat) begin
                r_sat <= 1'b1;
            end

            if (w_rem_dec) begin
                r_rem <= r_rem - ONE_P;
            end

            if (w_hcnt_inc) begin
                r_hcnt <= w_hcnt_plus;
            end

            if (w_pos_clr) begin
                if (r_axis) r_pos_y <= '0;
                else        r_pos_x <= '0;
            end else if (w_pos_inc) begin
                if (r_axis) r_pos_y <= r_pos_y + ONE_P;
                else        r_pos_x <= r_pos_x + ONE_P;
            end else if (w_pos_dec) begin
                if (r_axis) r_pos_y <= r_pos_y - ONE_P;
                else        r_pos_x <= r_pos_x - ONE_P;
            end
        end
    end

    assign w_active  = (r_state == S_MOVE) || (r_state == S_HOME);
    assign en_x      = w_active && !r_axis;
    assign en_y      = w_active && r_axis;
    assign dir_x     = w_dir_x;
    assign dir_y     = w_dir_y;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    // An abort arriving during the DONE cycle cancels the completion pulse.
    assign done      = (r_state == S_DONE) && !abort;
    assign sat       = r_sat;
    assign fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_claw_motion_sequencer.sv
// Self-checking bench for claw_motion_sequencer: table of move/home commands plus directed corner-case sequences.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: waits on busy are bounded; an expired wait counts as a failure.
module tb_claw_motion_sequencer;

    localparam int POS_W = 12;

    logic             clk;
    logic             rst;
    logic             step_tick;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_axis;
    logic             cmd_home;
    logic             cmd_dir;
    logic [POS_W-1:0] cmd_steps;
    logic             limit_x;
    logic             limit_y;
    logic             abort;
    logic             en_x;
    logic             dir_x;
    logic             en_y;
    logic             dir_y;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             busy;
    logic             done;
    logic             sat;
    logic             fault;

    claw_motion_sequencer #(
        .POS_W   (POS_W),
        .X_MAX   (2000),
        .Y_MAX   (1500),
        .HOME_MAX(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_tick(step_tick),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_axis (cmd_axis),
        .cmd_home (cmd_home),
        .cmd_dir  (cmd_dir),
        .cmd_steps(cmd_steps),
        .limit_x  (limit_x),
        .limit_y  (limit_y),
        .abort    (abort),
        .en_x     (en_x),
        .dir_x    (dir_x),
        .en_y     (en_y),
        .dir_y    (dir_y),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .busy     (busy),
        .done     (done),
        .sat      (sat),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Running totals sampled mid-cycle; the main sequence works with deltas.
    int done_tot = 0;
    int enx_tot  = 0;
    int eny_tot  = 0;
    int acc_tot  = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_tot++;
        if (en_x === 1'b1) enx_tot++;
        if (en_y === 1'b1) eny_tot++;
        if ((cmd_valid === 1'b1) && (cmd_ready === 1'b1)) acc_tot++;
    end

    typedef struct {
        logic axis;
        logic home;
        logic dir;
        int   steps;
        int   ticks;
        logic lim;    // raise the axis limit switch after the ticks
        int   px;
        int   py;
        logic sat;
        logic dx;
        logic dy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic axis, input logic home, input logic dir, input int steps);
        cmd_axis  = axis;
        cmd_home  = home;
        cmd_dir   = dir;
        cmd_steps = POS_W'(steps);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy !== 1'b0) && (k < 100)) begin
            cyc();
            k++;
        end
        check({name, " idle within bound"}, int'(busy === 1'b0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, ex0, ey0, a0;

        //         axis  home  dir  steps ticks lim   px    py    sat   dx    dy
        vecs[0] = '{1'b0, 1'b0, 1'b1, 5,    5,    1'b0, 5,    0,    1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1498, 1498, 1'b0, 5,    1498, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 10,   3,    1'b0, 5,    1500, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3,    3,    1'b0, 2,    1500, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 0,    7,    1'b1, 0,    1500, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3,    3,    1'b0, 3,    1500, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 10,   4,    1'b0, 0,    1500, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 100,  2,    1'b1, 0,    0,    1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        step_tick = 1'b0;
        cmd_valid = 1'b0;
        cmd_axis  = 1'b0;
        cmd_home  = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        limit_x   = 1'b0;
        limit_y   = 1'b0;
        abort     = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst busy",      int'(busy),      0);
        check("rst pos_x",     int'(pos_x),     0);
        check("rst pos_y",     int'(pos_y),     0);
        check("rst en",        int'({en_x, en_y}),   0);
        check("rst dir",       int'({dir_x, dir_y}), 0);
        check("rst flags",     int'({done, sat, fault}), 0);

        // Table of commands
        for (int i = 0; i < 8; i++) begin
            d0  = done_tot;
            ex0 = enx_tot;
            ey0 = eny_tot;
            issue(vecs[i].axis, vecs[i].home, vecs[i].dir, vecs[i].steps);
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            if (vecs[i].lim) begin
                if (vecs[i].axis) limit_y = 1'b1;
                else              limit_x = 1'b1;
            end
            wait_idle($sformatf("v%0d", i));
            limit_x = 1'b0;
            limit_y = 1'b0;
            cyc();
            check($sformatf("v%0d pos_x", i), int'(pos_x), vecs[i].px);
            check($sformatf("v%0d pos_y", i), int'(pos_y), vecs[i].py);
            check($sformatf("v%0d sat", i),   int'(sat),   int'(vecs[i].sat));
            check($sformatf("v%0d fault", i), int'(fault), 0);
            check($sformatf("v%0d dir_x", i), int'(dir_x), int'(vecs[i].dx));
            check($sformatf("v%0d dir_y", i), int'(dir_y), int'(vecs[i].dy));
            check($sformatf("v%0d done pulses", i), done_tot - d0, 1);
            if (vecs[i].axis) begin
                check($sformatf("v%0d en_x unused", i), enx_tot - ex0, 0);
                check($sformatf("v%0d en_y active", i), int'((eny_tot - ey0) > 0), 1);
            end else begin
                check($sformatf("v%0d en_y unused", i), eny_tot - ey0, 0);
                check($sformatf("v%0d en_x active", i), int'((enx_tot - ex0) > 0), 1);
            end
        end

        // Zero-step command: MOVE for one cycle, done two cycles after accept
        issue(1'b0, 1'b0, 1'b1, 0);
        check("zero move cycle done", int'(done), 0);
        check("zero move cycle busy", int'(busy), 1);
        cyc();
        check("zero done pulse", int'(done),  1);
        check("zero pos_x",      int'(pos_x), 0);
        cyc();
        check("zero done ends",  int'(done),      0);
        check("zero ready",      int'(cmd_ready), 1);

        // cmd_valid held through a move: only one accept
        a0 = acc_tot;
        cmd_axis  = 1'b0;
        cmd_home  = 1'b0;
        cmd_dir   = 1'b1;
        cmd_steps = POS_W'(2);
        cmd_valid = 1'b1;
        cyc();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
        cyc();
        step_tick = 1'b1;
        cyc();
        check("held done after 2nd tick", int'(done), 1);
        step_tick = 1'b0;
        cmd_valid = 1'b0;
        cyc();
        cyc();
        check("held accepts", acc_tot - a0, 1);
        check("held pos_x",   int'(pos_x),  2);
        check("held idle",    int'(busy),   0);

        // Homing timeout with HOME_MAX = 16, then abort out of FAULT
        d0 = done_tot;
        issue(1'b0, 1'b1, 1'b1, 0);
        for (int t = 0; t < 15; t++) tick();
        check("home 15 ticks fault", int'(fault), 0);
        check("home 15 ticks en_x",  int'(en_x),  1);
        check("home dir_x",          int'(dir_x), 0);
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        check("home timeout fault", int'(fault), 1);
        check("home timeout en_x",  int'(en_x),  0);
        check("home timeout busy",  int'(busy),  1);
        cyc();
        cyc();
        check("fault holds", int'(fault), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort clears fault", int'(fault),     0);
        check("abort fault ready",  int'(cmd_ready), 1);
        check("fault pos_x kept",   int'(pos_x),     2);
        cyc();
        check("fault no done", done_tot - d0, 0);

        // Abort in the same cycle as the fourth tick
        d0 = done_tot;
        issue(1'b0, 1'b0, 1'b1, 100);
        for (int t = 0; t < 3; t++) tick();
        step_tick = 1'b1;
        abort     = 1'b1;
        cyc();
        step_tick = 1'b0;
        abort     = 1'b0;
        check("abort pos_x",  int'(pos_x),     5);
        check("abort en_x",   int'(en_x),      0);
        check("abort ready",  int'(cmd_ready), 1);
        cyc();
        cyc();
        check("abort no done", done_tot - d0, 0);

        // Reset in the middle of a move
        d0 = done_tot;
        issue(1'b0, 1'b0, 1'b1, 100);
        for (int t = 0; t < 35; t++) tick();
        check("pre-reset pos_x", int'(pos_x), 40);
        check("pre-reset dir_x", int'(dir_x), 1);
        rst = 1'b1;
        cyc();
        check("mid rst pos_x", int'(pos_x),     0);
        check("mid rst busy",  int'(busy),      0);
        check("mid rst en_x",  int'(en_x),      0);
        check("mid rst dir_x", int'(dir_x),     0);
        check("mid rst ready", int'(cmd_ready), 1);
        check("mid rst flags", int'({done, sat, fault}), 0);
        rst = 1'b0;
        cyc();
        check("mid rst no done", done_tot - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
